// File: rtl/adc_capture_ctrl.sv
// Register-controlled dual-channel ADC capture sequencer with a sample-pair buffer,
// immediate or level trigger, decimation, and an MCU-drained auto-incrementing data register.
module adc_capture_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [13:0] ad_porta_data,
  input  logic [13:0] ad_portb_data,
  input  logic        ad_ofa,
  input  logic        ad_ofb,
  output logic        mcu_int,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0]  REG_CTRL  = 4'h0;
  localparam logic [3:0]  REG_STAT  = 4'h1;
  localparam logic [3:0]  REG_LEN   = 4'h2;
  localparam logic [3:0]  REG_DECIM = 4'h3;
  localparam logic [3:0]  REG_TRIG  = 4'h4;
  localparam logic [3:0]  REG_DATA  = 4'h5;
  localparam logic [15:0] DEPTH16   = 16'(DEPTH);
  localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);

  state_t        state_q;
  logic [15:0]   len_q, decim_q, dec_q;
  logic [13:0]   trig_lvl_q, prev_a_q;
  logic          trig_mode_q, ovr_a_q, ovr_b_q, irq_q, armed_seen_q, busy_q;
  logic [AW:0]   len_lat_q, cnt_q;
  logic [AW-1:0] rd_ptr_q;
  logic [31:0]   bus_rdata_q;
  logic [27:0]   mem [DEPTH];

  logic          ctrl_wr, start, abort, irq_clr, ctrl_act;
  logic          crossing, adv_dec, store, last;
  logic [AW:0]   len_clamp;
  logic [27:0]   rd_word;
  logic [31:0]   rdata_d;
  logic [15:0]   unused_wdata;

  assign unused_wdata = bus_wdata[31:16];

  assign ctrl_wr  = bus_wr && (bus_addr == REG_CTRL);
  assign start    = ctrl_wr && bus_wdata[0];
  assign abort    = ctrl_wr && bus_wdata[1];
  assign irq_clr  = ctrl_wr && bus_wdata[3];
  assign ctrl_act = start || abort;

  // The first ARMED cycle has no valid "previous" sample from this arming, so it is skipped.
  assign crossing = armed_seen_q && (prev_a_q < trig_lvl_q) && (ad_porta_data >= trig_lvl_q);
  assign adv_dec  = !ctrl_act && ((state_q == CAPTURE) || (state_q == ARMED && crossing));
  assign store    = adv_dec && (dec_q == 16'd0);
  assign last     = store && ((cnt_q + 1'b1) == len_lat_q);

  assign len_clamp = (len_q == 16'd0 || len_q > DEPTH16) ? DEPTH_W : len_q[AW:0];
  assign rd_word   = mem[rd_ptr_q];

  always_comb begin
    rdata_d = '0;
    case (bus_addr)
      REG_STAT:  rdata_d = {16'(cnt_q), 11'd0, irq_q, ovr_b_q, ovr_a_q, state_q};
      REG_LEN:   rdata_d = {16'd0, len_q};
      REG_DECIM: rdata_d = {16'd0, decim_q};
      REG_TRIG:  rdata_d = {18'd0, trig_lvl_q};
      REG_DATA:  rdata_d = {2'b00, rd_word[27:14], 2'b00, rd_word[13:0]};
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (store) mem[cnt_q[AW-1:0]] <= {ad_porta_data, ad_portb_data};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      len_q        <= DEPTH16;
      decim_q      <= '0;
      trig_lvl_q   <= 14'h2000;
      trig_mode_q  <= 1'b0;
      len_lat_q    <= DEPTH_W;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      dec_q        <= '0;
      ovr_a_q      <= 1'b0;
      ovr_b_q      <= 1'b0;
      irq_q        <= 1'b0;
      prev_a_q     <= '0;
      armed_seen_q <= 1'b0;
      busy_q       <= 1'b0;
      bus_rdata_q  <= '0;
    end else begin
      prev_a_q <= ad_porta_data;
      if (bus_wr) begin
        case (bus_addr)
          REG_CTRL:  trig_mode_q <= bus_wdata[2];
          REG_LEN:   len_q       <= bus_wdata[15:0];
          REG_DECIM: decim_q     <= bus_wdata[15:0];
          REG_TRIG:  trig_lvl_q  <= bus_wdata[13:0];
          default:   ;
        endcase
      end
      // Completion beats a simultaneous clear so a finished capture is never lost.
      if (last) irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
      if (bus_rd) begin
        bus_rdata_q <= rdata_d;
        if (bus_addr == REG_DATA) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (store) begin
        cnt_q   <= cnt_q + 1'b1;
        ovr_a_q <= ovr_a_q | ad_ofa;
        ovr_b_q <= ovr_b_q | ad_ofb;
      end
      if (adv_dec) dec_q <= (dec_q == decim_q) ? 16'd0 : dec_q + 16'd1;

      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q      <= bus_wdata[2] ? ARMED : CAPTURE;
        busy_q       <= 1'b1;
        cnt_q        <= '0;
        rd_ptr_q     <= '0;
        dec_q        <= '0;
        ovr_a_q      <= 1'b0;
        ovr_b_q      <= 1'b0;
        armed_seen_q <= 1'b0;
        len_lat_q    <= len_clamp;
      end else begin
        case (state_q)
          ARMED: begin
            armed_seen_q <= 1'b1;
            if (store) begin
              state_q <= last ? DONE : CAPTURE;
              busy_q  <= !last;
            end
          end
          CAPTURE: begin
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign mcu_int   = irq_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl: register table plus hand-built
// capture sequences (immediate, decimated, level trigger, abort, overflow, reset).
module tb_adc_capture_ctrl;

  logic        sys_clk, sys_rst, bus_wr, bus_rd;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [13:0] ad_porta_data, ad_portb_data;
  logic        ad_ofa, ad_ofb, mcu_int, busy;

  int          cyc, checks, errors, n, t;
  bit          ramp;
  logic [31:0] d;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [15];

  adc_capture_ctrl #(.DEPTH(1024), .AW(10)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .bus_wr        (bus_wr),
    .bus_rd        (bus_rd),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .ad_porta_data (ad_porta_data),
    .ad_portb_data (ad_portb_data),
    .ad_ofa        (ad_ofa),
    .ad_ofb        (ad_ofb),
    .mcu_int       (mcu_int),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (ramp) begin
      ad_porta_data = 14'(cyc);
      ad_portb_data = 14'(cyc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    bus_addr  = a;
    bus_wdata = v;
    bus_wr    = 1'b1;
    step();
    bus_wr    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    bus_addr = a;
    bus_rd   = 1'b1;
    step();
    bus_rd   = 1'b0;
    v        = bus_rdata;
  endtask

  // Interrupt must be low in cycle tdone-1 and high in cycle tdone.
  task automatic expect_done(input int tdone, input string name);
    while (cyc < tdone - 1) step();
    chk({name, "_early"}, 32'(mcu_int), 32'd0);
    step();
    chk(name, 32'(mcu_int), 32'd1);
  endtask

  initial begin
    sys_clk = 1'b0; sys_rst = 1'b1; bus_wr = 1'b0; bus_rd = 1'b0;
    bus_addr = '0; bus_wdata = '0; ad_porta_data = '0; ad_portb_data = '0;
    ad_ofa = 1'b0; ad_ofb = 1'b0; ramp = 1'b0;
    cyc = 0; checks = 0; errors = 0;

    vecs[0]  = '{1'b0, 4'h1, 32'h0,         32'h0000_0000, "rst_status"};
    vecs[1]  = '{1'b0, 4'h2, 32'h0,         32'h0000_0400, "rst_len"};
    vecs[2]  = '{1'b0, 4'h3, 32'h0,         32'h0000_0000, "rst_decim"};
    vecs[3]  = '{1'b0, 4'h4, 32'h0,         32'h0000_2000, "rst_trig"};
    vecs[4]  = '{1'b1, 4'h2, 32'h0001_2345, 32'h0,         "w_len"};
    vecs[5]  = '{1'b0, 4'h2, 32'h0,         32'h0000_2345, "len_16b"};
    vecs[6]  = '{1'b1, 4'h3, 32'hFFFF_ABCD, 32'h0,         "w_decim"};
    vecs[7]  = '{1'b0, 4'h3, 32'h0,         32'h0000_ABCD, "decim_16b"};
    vecs[8]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0,         "w_trig"};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,         32'h0000_3FFF, "trig_14b"};
    vecs[10] = '{1'b1, 4'h7, 32'h0000_1234, 32'h0,         "w_unmapped"};
    vecs[11] = '{1'b0, 4'h7, 32'h0,         32'h0000_0000, "rd_unmapped"};
    vecs[12] = '{1'b0, 4'h2, 32'h0,         32'h0000_2345, "len_kept"};
    vecs[13] = '{1'b0, 4'h0, 32'h0,         32'h0000_0000, "rd_ctrl"};
    vecs[14] = '{1'b0, 4'hF, 32'h0,         32'h0000_0000, "rd_addr_f"};

    #1;
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_int", 32'(mcu_int), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (3) step();
    sys_rst = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else begin
        rd(vecs[i].addr, d);
        chk(vecs[i].name, d, vecs[i].exp);
      end
    end

    // Immediate capture, LEN=4, DECIM=0, ramp on both channels.
    wr(4'h2, 32'd4); wr(4'h3, 32'd0);
    ramp = 1'b1;
    step();
    n = cyc;
    wr(4'h0, 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    expect_done(n + 5, "t1_done");
    chk("t1_busy_done", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd(4'h5, d);
      chk("t1_data", d, {2'b00, 14'(n + 1 + k), 2'b00, 14'(n + 1 + k)});
    end
    repeat (3) step();
    chk("t1_rdata_hold", bus_rdata, {2'b00, 14'(n + 4), 2'b00, 14'(n + 4)});
    rd(4'h1, d);
    chk("t1_status", d, 32'h0004_0013);

    // LEN=3, DECIM=2: pairs three cycles apart, done at N+8.
    wr(4'h0, 32'h8); wr(4'h2, 32'd3); wr(4'h3, 32'd2);
    chk("t2_irq_clr", 32'(mcu_int), 32'd0);
    n = cyc;
    wr(4'h0, 32'h1);
    expect_done(n + 8, "t2_done");
    for (int k = 0; k < 3; k++) begin
      rd(4'h5, d);
      chk("t2_data", d, {2'b00, 14'(n + 1 + 3 * k), 2'b00, 14'(n + 1 + 3 * k)});
    end

    // Level trigger: no trigger on an initially high level, pair 0 is the crossing sample.
    ramp = 1'b0;
    ad_porta_data = 14'h2100; ad_portb_data = 14'h0055;
    wr(4'h4, 32'h2000); wr(4'h2, 32'd2); wr(4'h3, 32'd0); wr(4'h0, 32'h8);
    wr(4'h0, 32'h5);
    rd(4'h1, d);
    chk("t3_armed", 32'(d[1:0]), 32'd1);
    repeat (3) step();
    chk("t3_busy_armed", 32'(busy), 32'd1);
    chk("t3_no_trig", 32'(mcu_int), 32'd0);
    ad_porta_data = 14'h1000;
    step();
    ad_porta_data = 14'h2000;
    t = cyc;
    step();
    ad_porta_data = 14'h2001;
    expect_done(t + 2, "t3_done");
    rd(4'h5, d);
    chk("t3_pair0", d, 32'h2000_0055);
    rd(4'h5, d);
    chk("t3_pair1", d, 32'h2001_0055);

    // Abort mid-capture.
    wr(4'h0, 32'h8); wr(4'h2, 32'd16);
    wr(4'h0, 32'h1);
    repeat (3) step();
    chk("t4_busy_run", 32'(busy), 32'd1);
    wr(4'h0, 32'h2);
    chk("t4_busy_abort", 32'(busy), 32'd0);
    rd(4'h1, d);
    chk("t4_state_idle", 32'(d[4:0]), 32'd0);
    repeat (20) step();
    chk("t4_no_int", 32'(mcu_int), 32'd0);

    // LEN=0 clamps to DEPTH.
    wr(4'h2, 32'd0);
    n = cyc;
    wr(4'h0, 32'h1);
    expect_done(n + 1025, "t4_len0_done");
    rd(4'h1, d);
    chk("t4_len0_status", d, 32'h0400_0013);
    wr(4'h0, 32'h8);
    wr(4'h0, 32'h3);
    chk("t4_startabort_busy", 32'(busy), 32'd0);
    rd(4'h1, d);
    chk("t4_startabort_status", d, 32'h0400_0000);

    // Over-range on stored vs skipped sample; irq_clr coincident with completion.
    wr(4'h2, 32'd3); wr(4'h3, 32'd1);
    n = cyc;
    wr(4'h0, 32'h1);
    step();
    ad_ofa = 1'b1;
    step();
    ad_ofa = 1'b0; ad_ofb = 1'b1;
    step();
    ad_ofb = 1'b0;
    step();
    chk("t5_cycle", 32'(cyc), 32'(n + 5));
    wr(4'h0, 32'h8);
    chk("t5_set_wins", 32'(mcu_int), 32'd1);
    rd(4'h1, d);
    chk("t5_status_ovr", d, 32'h0003_001B);
    wr(4'h0, 32'h8); wr(4'h2, 32'd1);
    n = cyc;
    wr(4'h0, 32'h1);
    expect_done(n + 2, "t5_len1_done");
    rd(4'h1, d);
    chk("t5_ovr_cleared", d, 32'h0001_0013);

    // Asynchronous reset mid-capture.
    wr(4'h2, 32'd16);
    wr(4'h0, 32'h1);
    repeat (3) step();
    chk("t6_pre_busy", 32'(busy), 32'd1);
    chk("t6_pre_int", 32'(mcu_int), 32'd1);
    sys_rst = 1'b1;
    #1;
    chk("t6_rdata", bus_rdata, 32'h0);
    chk("t6_int", 32'(mcu_int), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    step();
    sys_rst = 1'b0;
    step();
    rd(4'h2, d);
    chk("t6_len", d, 32'h0000_0400);
    rd(4'h1, d);
    chk("t6_status", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Register-controlled capture sequencer for the dual 14-bit ADC datapath, sitting between the FSMC bus bridge and the two ADC ports. The MCU programs length, decimation and trigger. The block then captures paired channel A/B samples into an internal buffer and raises `mcu_int` when the capture is done. The MCU drains the buffer through a single auto-incrementing data register, which replaces the direct ADC-to-read-bus connection.

## Interface
- `DEPTH`, default 1024: buffer depth in sample pairs; power of two.
- `AW`, default 10: log2(DEPTH).
- `sys_clk`  in  1: system clock; all logic is on its rising edge; ADC inputs are already in this domain.
- `sys_rst`  in  1: asynchronous, active-high reset.
- `bus_wr`  in  1: one-cycle write strobe from the bus bridge.
- `bus_rd`  in  1: one-cycle read strobe from the bus bridge.
- `bus_addr`  in  4: word register address.
- `bus_wdata`  in  32: write data.
- `bus_rdata`  out  32: registered read data.
- `ad_porta_data`  in  14: channel A sample, offset binary.
- `ad_portb_data`  in  14: channel B sample, offset binary.
- `ad_ofa`, `ad_ofb`  in  1 each: per-channel over-range flags.
- `mcu_int`  out  1: level interrupt, set on capture completion.
- `busy`  out  1: high in ARMED or CAPTURE.

## Operation
- Register map:
  - 0x0 CTRL, W. Bit0 start, bit1 abort, bit2 trig_mode (0 immediate, 1 level), bit3 irq_clr. All bits are self-clearing except trig_mode, which is stored.
  - 0x1 STATUS, R. [1:0] state (IDLE 0, ARMED 1, CAPTURE 2, DONE 3), [2] ovr_a, [3] ovr_b, [4] irq, [31:16] stored-sample count.
  - 0x2 LEN, RW, 16 bits. Number of pairs to capture; 0 or any value >DEPTH is clamped to DEPTH when start is written.
  - 0x3 DECIM, RW, 16 bits. Store one pair every DECIM+1 cycles.
  - 0x4 TRIG_LVL, RW, 14 bits.
  - 0x5 DATA, R. Returns {2'b0,A,2'b0,B} at the read pointer; the pointer increments (mod DEPTH) after each DATA read.
  - Unmapped reads return 0; unmapped writes are ignored.
- FSM:
  - IDLE: on start, go to CAPTURE if trig_mode=0, else to ARMED.
  - ARMED: stay until a rising crossing, then store that sample as pair 0 and go to CAPTURE. A rising crossing is a cycle with the previous cycle's A < TRIG_LVL and the current A >= TRIG_LVL, compared unsigned. A crossing is evaluated only from the second ARMED cycle onward.
  - CAPTURE: a decimation counter runs 0..DECIM; a pair is stored when the counter is 0. After LEN pairs are stored, go to DONE.
  - DONE: stay until the next start or abort.
- Start in any state (restart included) clears the write address, read pointer, sample count, ovr_a/ovr_b and the decimation counter, and latches the clamped LEN.
- Abort in any state goes to IDLE and does not set irq. If start and abort are written in the same word, abort wins.
- ovr_a / ovr_b are sticky. They set when the corresponding flag is high on a stored sample.
- irq is set on the CAPTURE→DONE (or ARMED→DONE when LEN=1) transition and cleared by irq_clr. If set and clear occur in the same cycle, set wins. `mcu_int` = irq.
- The buffer is a simple dual-port RAM: write side for capture, read side for DATA. Reads are legal in every state; reading during capture returns whatever is currently stored.

## Timing
- Reset values: `bus_rdata`=0, `mcu_int`=0, `busy`=0, state IDLE, LEN=DEPTH, DECIM=0, TRIG_LVL=0x2000, trig_mode=0, pointers/count=0, ovr flags=0.
- Writes take effect in the cycle after `bus_wr`.
- `bus_rdata` is valid the cycle after `bus_rd` and holds until the next read.
- Immediate mode: start is written in cycle N. The state is CAPTURE in N+1, and the pair present in N+1 is pair 0. With DECIM=d, pair k is taken in cycle N+1+k(d+1).
- Level mode: a crossing in cycle T stores pair 0 at T; pair k is stored at T+k(d+1).
- The last pair is stored in cycle L. The state is DONE and `mcu_int`=1 from L+1.
- `busy` follows the registered state.

## Test plan
- Immediate, LEN=4, DECIM=0, ramp on A (A=B=cycle index): `mcu_int` rises 5 cycles after start; four DATA reads return consecutive values packed as {2'b0,A,2'b0,B}; STATUS[31:16]=4.
- LEN=3, DECIM=2: stored samples are spaced exactly 3 cycles apart; done occurs at N+8.
- Level mode, TRIG_LVL=0x2000, A held at 0x2100 then dropped to 0x1000 and stepped to 0x2000: no trigger on the initial high level; pair 0 = 0x2000.
- Abort mid-capture: state returns to IDLE, `mcu_int` stays 0. Start with LEN=0 then captures DEPTH pairs. Start+abort in one write leaves the state IDLE.
- `ad_ofb` pulsed on one stored sample: STATUS[3]=1 until the next start. irq_clr written in the same cycle as completion: `mcu_int` remains 1.
- `sys_rst` asserted mid-capture: all outputs return to their reset values immediately.
